// File: rtl/fir_ffa2_param.sv
// 2-parallel fast-FIR (FFA) with run-time loadable coefficients.
// Sub-filters H0, H1, H0+H1 feed a two-stage output pipeline.
module fir_ffa2_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40,
  parameter int TAPS   = 170
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          coef_start,
  input  logic                          coef_valid,
  input  logic [COEF_W-1:0]             coef_data,
  output logic                          coef_busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0][DATA_W-1:0]        inp,
  output logic                          out_valid,
  output logic [1:0][ACC_W-1:0]         outp
);

  if (TAPS < 2 || (TAPS % 2) != 0) begin : g_taps_chk
    $error("TAPS must be even and >= 2");
  end

  localparam int M   = TAPS / 2;
  localparam int CW  = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int PW  = DATA_W + COEF_W;
  localparam int P2W = DATA_W + COEF_W + 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_nx;

  logic [CW-1:0]              cnt;
  logic signed [COEF_W-1:0]   h   [TAPS];
  logic signed [DATA_W-1:0]   d0  [M];
  logic signed [DATA_W-1:0]   d1  [M];
  logic signed [DATA_W:0]     d01 [M];
  logic signed [ACC_W-1:0]    sa, sb, sc;
  logic signed [ACC_W-1:0]    a, b, c, h1_prev;
  logic signed [DATA_W-1:0]   x0, x1;
  logic signed [DATA_W:0]     x01;
  logic                       v0, v1;
  logic                       wr, accept, last;

  assign x0  = $signed(inp[0]);
  assign x1  = $signed(inp[1]);
  assign x01 = (DATA_W+1)'(x0) + (DATA_W+1)'(x1);

  assign coef_busy = (state == LOAD);
  assign in_ready  = (state == RUN);
  assign wr        = coef_busy & coef_valid & ~coef_start;
  assign last      = (cnt == CW'(TAPS - 1));
  assign accept    = in_valid & in_ready & ~coef_start;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (coef_start) state_nx = LOAD;
      LOAD: begin
        if (coef_start)      state_nx = LOAD;
        else if (wr && last) state_nx = RUN;
      end
      RUN:  if (coef_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Direct-form sub-filter sums, wrapping in ACC_W bits
  always_comb begin
    logic signed [PW-1:0]   p0, p1;
    logic signed [P2W-1:0]  p2;
    logic signed [COEF_W:0] hs;
    sa = '0;
    sb = '0;
    sc = '0;
    for (int i = 0; i < M; i++) begin
      hs = (COEF_W+1)'(h[2*i]) + (COEF_W+1)'(h[2*i+1]);
      p0 = PW'(d0[i]) * PW'(h[2*i]);
      p1 = PW'(d1[i]) * PW'(h[2*i+1]);
      p2 = P2W'(d01[i]) * P2W'(hs);
      sa = sa + ACC_W'(p0);
      sb = sb + ACC_W'(p1);
      sc = sc + ACC_W'(p2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < TAPS; i++) h[i] <= '0;
    end else if (coef_start) begin
      cnt <= '0;
    end else if (wr) begin
      h[cnt] <= $signed(coef_data);
      cnt    <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      for (int i = 0; i < M; i++) begin
        d0[i]  <= '0;
        d1[i]  <= '0;
        d01[i] <= '0;
      end
    end else if (coef_start) begin
      v0 <= 1'b0;
      for (int i = 0; i < M; i++) begin
        d0[i]  <= '0;
        d1[i]  <= '0;
        d01[i] <= '0;
      end
    end else begin
      v0 <= accept;
      if (accept) begin
        d0[0]  <= x0;
        d1[0]  <= x1;
        d01[0] <= x01;
        for (int i = 1; i < M; i++) begin
          d0[i]  <= d0[i-1];
          d1[i]  <= d1[i-1];
          d01[i] <= d01[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      c         <= '0;
      v1        <= 1'b0;
      h1_prev   <= '0;
      out_valid <= 1'b0;
      outp      <= '0;
    end else begin
      a         <= sa;
      b         <= sb;
      c         <= sc;
      v1        <= v0 & ~coef_start;
      out_valid <= v1 & ~coef_start;
      if (coef_start) begin
        h1_prev <= '0;
      end else if (v1) begin
        h1_prev <= b;
        outp[0] <= a + h1_prev;
        outp[1] <= c - a - b;
      end
    end
  end

endmodule
